// File: rtl/cci_mpf_null_fiu_responder_if.sv
// Request/response bundle between an AFU-side requester and the null FIU
// responder. The master drives requests; the slave drives responses and flags.
interface cci_mpf_null_fiu_responder_if;
   logic         c0_req_valid;
   logic [41:0]  c0_req_addr;
   logic [15:0]  c0_req_mdata;
   logic [1:0]   c0_req_cl_len;
   logic         c0TxAlmFull;
   logic         c0_rsp_valid;
   logic [15:0]  c0_rsp_mdata;
   logic [1:0]   c0_rsp_cl_num;
   logic [511:0] c0_rsp_data;

   logic         c1_req_valid;
   logic         c1_req_is_fence;
   logic [15:0]  c1_req_mdata;
   logic         c1TxAlmFull;
   logic         c1_rsp_valid;
   logic [15:0]  c1_rsp_mdata;
   logic         c1_rsp_is_fence;

   logic [1:0]   err_sticky;

   modport master (
      output c0_req_valid, c0_req_addr, c0_req_mdata, c0_req_cl_len,
      output c1_req_valid, c1_req_is_fence, c1_req_mdata,
      input  c0TxAlmFull, c0_rsp_valid, c0_rsp_mdata, c0_rsp_cl_num, c0_rsp_data,
      input  c1TxAlmFull, c1_rsp_valid, c1_rsp_mdata, c1_rsp_is_fence,
      input  err_sticky
   );

   modport slave (
      input  c0_req_valid, c0_req_addr, c0_req_mdata, c0_req_cl_len,
      input  c1_req_valid, c1_req_is_fence, c1_req_mdata,
      output c0TxAlmFull, c0_rsp_valid, c0_rsp_mdata, c0_rsp_cl_num, c0_rsp_data,
      output c1TxAlmFull, c1_rsp_valid, c1_rsp_mdata, c1_rsp_is_fence,
      output err_sticky
   );
endinterface

// File: rtl/cci_mpf_null_fiu_responder.sv
// Null FIU responder: queues read (c0) and write/fence (c1) requests, holds
// each for at least LATENCY cycles using a wrapping timestamp, then answers
// in order. Read data is synthesised from the request address.
module cci_mpf_null_fiu_responder #(
   parameter int unsigned LATENCY            = 8,
   parameter int unsigned DEPTH              = 64,
   parameter int unsigned ALM_FULL_THRESHOLD = 8
) (
   input logic                         clk,
   input logic                         reset,
   cci_mpf_null_fiu_responder_if.slave bus
);
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [15:0] LAT16    = 16'(LATENCY);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ALM_LVL  = (AW+1)'(DEPTH - ALM_FULL_THRESHOLD);
   localparam logic [AW:0] CNT_INC  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_INC = AW'(1);

   logic [15:0]   ts;

   logic [41:0]   c0_addr_mem  [DEPTH];
   logic [15:0]   c0_mdata_mem [DEPTH];
   logic [1:0]    c0_len_mem   [DEPTH];
   logic [15:0]   c0_ts_mem    [DEPTH];
   logic [AW-1:0] c0_wr_ptr, c0_rd_ptr;
   logic [AW:0]   c0_count;
   logic [1:0]    c0_beat;
   logic [15:0]   c0_age;
   logic          c0_head_ok, c0_last, c0_pop, c0_push, c0_legal, c0_full;

   logic [15:0]   c1_mdata_mem [DEPTH];
   logic          c1_fence_mem [DEPTH];
   logic [15:0]   c1_ts_mem    [DEPTH];
   logic [AW-1:0] c1_wr_ptr, c1_rd_ptr;
   logic [AW:0]   c1_count;
   logic [15:0]   c1_age;
   logic          c1_head_ok, c1_pop, c1_push, c1_full;

   // Head eligibility and push/pop decisions. Modular age makes the timestamp
   // wrap invisible; a pop frees a slot for a same-cycle push on a full queue.
   always_comb begin
      c0_full    = (c0_count == FULL_LVL);
      c0_age     = ts - c0_ts_mem[c0_rd_ptr];
      c0_head_ok = (c0_count != '0) && (c0_age >= LAT16);
      // cl_len 0/1/3 map to last beat 0/1/3, so the length is the last index
      c0_last    = (c0_beat == c0_len_mem[c0_rd_ptr]);
      c0_pop     = c0_head_ok && c0_last;
      c0_legal   = (bus.c0_req_cl_len != 2'd2);
      c0_push    = bus.c0_req_valid && c0_legal && (!c0_full || c0_pop);

      c1_full    = (c1_count == FULL_LVL);
      c1_age     = ts - c1_ts_mem[c1_rd_ptr];
      c1_head_ok = (c1_count != '0) && (c1_age >= LAT16);
      c1_pop     = c1_head_ok;
      c1_push    = bus.c1_req_valid && (!c1_full || c1_pop);
   end

   // Queue payload storage; pointers and occupancy carry the reset.
   always_ff @(posedge clk) begin
      if (c0_push) begin
         c0_addr_mem[c0_wr_ptr]  <= bus.c0_req_addr;
         c0_mdata_mem[c0_wr_ptr] <= bus.c0_req_mdata;
         c0_len_mem[c0_wr_ptr]   <= bus.c0_req_cl_len;
         c0_ts_mem[c0_wr_ptr]    <= ts;
      end
      if (c1_push) begin
         c1_mdata_mem[c1_wr_ptr] <= bus.c1_req_mdata;
         c1_fence_mem[c1_wr_ptr] <= bus.c1_req_is_fence;
         c1_ts_mem[c1_wr_ptr]    <= ts;
      end
   end

   // Timestamp, queue control, registered responses, flags and error bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         ts                  <= '0;
         c0_wr_ptr           <= '0;
         c0_rd_ptr           <= '0;
         c0_count            <= '0;
         c0_beat             <= '0;
         c1_wr_ptr           <= '0;
         c1_rd_ptr           <= '0;
         c1_count            <= '0;
         bus.c0TxAlmFull     <= 1'b0;
         bus.c0_rsp_valid    <= 1'b0;
         bus.c0_rsp_mdata    <= '0;
         bus.c0_rsp_cl_num   <= '0;
         bus.c0_rsp_data     <= '0;
         bus.c1TxAlmFull     <= 1'b0;
         bus.c1_rsp_valid    <= 1'b0;
         bus.c1_rsp_mdata    <= '0;
         bus.c1_rsp_is_fence <= 1'b0;
         bus.err_sticky      <= '0;
      end else begin
         ts <= ts + 16'd1;

         if (c0_push) c0_wr_ptr <= c0_wr_ptr + PTR_INC;
         if (c0_pop)  c0_rd_ptr <= c0_rd_ptr + PTR_INC;
         case ({c0_push, c0_pop})
            2'b10:   c0_count <= c0_count + CNT_INC;
            2'b01:   c0_count <= c0_count - CNT_INC;
            default: c0_count <= c0_count;
         endcase
         if (c0_head_ok) c0_beat <= c0_last ? 2'd0 : c0_beat + 2'd1;

         if (c1_push) c1_wr_ptr <= c1_wr_ptr + PTR_INC;
         if (c1_pop)  c1_rd_ptr <= c1_rd_ptr + PTR_INC;
         case ({c1_push, c1_pop})
            2'b10:   c1_count <= c1_count + CNT_INC;
            2'b01:   c1_count <= c1_count - CNT_INC;
            default: c1_count <= c1_count;
         endcase

         bus.c0TxAlmFull   <= (c0_count >= ALM_LVL);
         bus.c1TxAlmFull   <= (c1_count >= ALM_LVL);

         bus.c0_rsp_valid  <= c0_head_ok;
         bus.c0_rsp_mdata  <= c0_head_ok ? c0_mdata_mem[c0_rd_ptr] : '0;
         bus.c0_rsp_cl_num <= c0_head_ok ? c0_beat : '0;
         bus.c0_rsp_data   <= c0_head_ok ?
                              {470'd0, c0_addr_mem[c0_rd_ptr] + 42'(c0_beat)} : '0;

         bus.c1_rsp_valid    <= c1_head_ok;
         bus.c1_rsp_mdata    <= c1_head_ok ? c1_mdata_mem[c1_rd_ptr] : '0;
         bus.c1_rsp_is_fence <= c1_head_ok ? c1_fence_mem[c1_rd_ptr] : 1'b0;

         if (bus.c0_req_valid && !c0_legal) bus.err_sticky[1] <= 1'b1;
         if ((bus.c0_req_valid && c0_legal && c0_full && !c0_pop) ||
             (bus.c1_req_valid && c1_full && !c1_pop))
            bus.err_sticky[0] <= 1'b1;
      end
   end
endmodule

// File: tb/tb_cci_mpf_null_fiu_responder.sv
// Self-checking bench for the null FIU responder. The reference model
// schedules every response line by cycle number from the latency and
// in-order rules, and tracks queue residency to predict drops and almost-full.
module tb_cci_mpf_null_fiu_responder;
   localparam int LAT   = 80;
   localparam int DEPTH = 64;
   localparam int THR   = 8;
   localparam int ALM_LVL = DEPTH - THR;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cci_mpf_null_fiu_responder_if bus ();

   cci_mpf_null_fiu_responder #(
      .LATENCY(LAT),
      .DEPTH(DEPTH),
      .ALM_FULL_THRESHOLD(THR)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      int          cyc;
      logic [15:0] mdata;
      logic [1:0]  cl_num;
      logic [41:0] data;
   } rd_rsp_t;

   typedef struct {
      int          cyc;
      logic [15:0] mdata;
      logic        fence;
   } wr_rsp_t;

   rd_rsp_t     c0_exp[$];
   wr_rsp_t     c1_exp[$];
   int          c0_res[$];   // final-line cycle of each resident read entry
   int          c1_res[$];
   int          c0_free, c1_free;
   int          c0_prev_occ, c1_prev_occ;
   logic [1:0]  err_exp;
   int          cyc;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic idle_inputs();
      bus.c0_req_valid    = 1'b0;
      bus.c0_req_addr     = '0;
      bus.c0_req_mdata    = '0;
      bus.c0_req_cl_len   = '0;
      bus.c1_req_valid    = 1'b0;
      bus.c1_req_is_fence = 1'b0;
      bus.c1_req_mdata    = '0;
   endtask

   task automatic drive_rd(input logic [41:0] a, input logic [15:0] m, input logic [1:0] l);
      bus.c0_req_valid  = 1'b1;
      bus.c0_req_addr   = a;
      bus.c0_req_mdata  = m;
      bus.c0_req_cl_len = l;
   endtask

   task automatic drive_wr(input logic [15:0] m, input logic f);
      bus.c1_req_valid    = 1'b1;
      bus.c1_req_mdata    = m;
      bus.c1_req_is_fence = f;
   endtask

   task automatic model_clear();
      c0_exp.delete();
      c1_exp.delete();
      c0_res.delete();
      c1_res.delete();
      c0_free = 0;
      c1_free = 0;
      c0_prev_occ = 0;
      c1_prev_occ = 0;
      err_exp = 2'b00;
      cyc = 0;
   endtask

   // Compare every output for the current cycle against the schedule.
   task automatic check_outputs();
      rd_rsp_t r;
      wr_rsp_t w;
      while (c0_res.size() > 0 && c0_res[0] <= cyc) void'(c0_res.pop_front());
      while (c1_res.size() > 0 && c1_res[0] <= cyc) void'(c1_res.pop_front());

      if (c0_exp.size() > 0 && c0_exp[0].cyc == cyc) begin
         r = c0_exp.pop_front();
         check("c0_valid", bus.c0_rsp_valid, 1'b1);
         check("c0_mdata", bus.c0_rsp_mdata, r.mdata);
         check("c0_cl_num", bus.c0_rsp_cl_num, r.cl_num);
         check("c0_data", bus.c0_rsp_data, {470'd0, r.data});
      end else begin
         check("c0_idle_valid", bus.c0_rsp_valid, 1'b0);
         check("c0_idle_fields", {bus.c0_rsp_mdata, bus.c0_rsp_cl_num}, '0);
         check("c0_idle_data", bus.c0_rsp_data, '0);
      end

      if (c1_exp.size() > 0 && c1_exp[0].cyc == cyc) begin
         w = c1_exp.pop_front();
         check("c1_valid", bus.c1_rsp_valid, 1'b1);
         check("c1_mdata", bus.c1_rsp_mdata, w.mdata);
         check("c1_fence", bus.c1_rsp_is_fence, w.fence);
      end else begin
         check("c1_idle_valid", bus.c1_rsp_valid, 1'b0);
         check("c1_idle_fields", {bus.c1_rsp_mdata, bus.c1_rsp_is_fence}, '0);
      end

      check("c0_alm", bus.c0TxAlmFull, c0_prev_occ >= ALM_LVL);
      check("c1_alm", bus.c1TxAlmFull, c1_prev_occ >= ALM_LVL);
      c0_prev_occ = c0_res.size();
      c1_prev_occ = c1_res.size();
      check("err_sticky", bus.err_sticky, err_exp);
   endtask

   // Apply the rules to the requests presented this cycle.
   task automatic model_accept();
      int n;
      int start;
      if (bus.c0_req_valid) begin
         if (bus.c0_req_cl_len == 2'd2) begin
            err_exp[1] = 1'b1;
         end else if (c0_res.size() < DEPTH || c0_res[0] == cyc + 1) begin
            n = (bus.c0_req_cl_len == 2'd3) ? 4 : int'(bus.c0_req_cl_len) + 1;
            start = (cyc + LAT + 1 > c0_free) ? cyc + LAT + 1 : c0_free;
            for (int k = 0; k < n; k++)
               c0_exp.push_back('{start + k, bus.c0_req_mdata, 2'(k),
                                  bus.c0_req_addr + 42'(k)});
            c0_res.push_back(start + n - 1);
            c0_free = start + n;
         end else begin
            err_exp[0] = 1'b1;
         end
      end
      if (bus.c1_req_valid) begin
         if (c1_res.size() < DEPTH || c1_res[0] == cyc + 1) begin
            start = (cyc + LAT + 1 > c1_free) ? cyc + LAT + 1 : c1_free;
            c1_exp.push_back('{start, bus.c1_req_mdata, bus.c1_req_is_fence});
            c1_res.push_back(start);
            c1_free = start + 1;
         end else begin
            err_exp[0] = 1'b1;
         end
      end
   endtask

   // One cycle: inputs for this cycle are already driven.
   task automatic step();
      @(negedge clk);
      check_outputs();
      model_accept();
      @(posedge clk);
      #1;
      cyc++;
      idle_inputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Reset with requests presented throughout, which must be ignored.
   task automatic apply_reset(input bit check_first, input int n);
      reset = 1'b1;
      drive_rd(42'h123, 16'hBEEF, 2'd0);
      drive_wr(16'hCAFE, 1'b0);
      if (check_first) begin
         @(negedge clk);
         check_outputs();
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("rst_c0_valid", bus.c0_rsp_valid, 1'b0);
         check("rst_c0_fields", {bus.c0_rsp_mdata, bus.c0_rsp_cl_num}, '0);
         check("rst_c0_data", bus.c0_rsp_data, '0);
         check("rst_c1", {bus.c1_rsp_valid, bus.c1_rsp_mdata, bus.c1_rsp_is_fence}, '0);
         check("rst_alm", {bus.c0TxAlmFull, bus.c1TxAlmFull}, '0);
         check("rst_err", bus.err_sticky, 2'b00);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      idle_inputs();
      model_clear();
   endtask

   initial begin
      int budget;
      logic [41:0] a;
      logic [1:0]  l;
      reset = 1'b1;
      idle_inputs();
      model_clear();
      apply_reset(1'b0, 3);

      // Single read, accepted in the first cycle after reset.
      drive_rd(42'h100, 16'h5, 2'd0);
      step();
      idle(LAT + 5);

      // Back-to-back multi-line reads, the second ending on the address wrap.
      drive_rd(42'h2000, 16'h1, 2'd3);
      step();
      drive_rd(42'h3FFFFFFFFFF, 16'h2, 2'd1);
      step();
      idle(LAT + 10);

      // Writes followed by a fence.
      drive_wr(16'd10, 1'b0); step();
      drive_wr(16'd11, 1'b0); step();
      drive_wr(16'd12, 1'b0); step();
      drive_wr(16'd13, 1'b1); step();
      idle(LAT + 6);

      // Illegal cl_len.
      drive_rd(42'h40, 16'h33, 2'd2);
      step();
      idle(LAT + 5);

      // Reset in the cycle cl_num=1 of a 4-line burst is on the outputs.
      drive_rd(42'h500, 16'h77, 2'd3);
      step();
      budget = 0;
      while (!(c0_exp.size() > 0 && c0_exp[0].cyc == cyc && c0_exp[0].cl_num == 2'd1)
             && budget < LAT + 20) begin
         step();
         budget++;
      end
      check("burst_reach_beat1", budget < LAT + 20, 1'b1);
      apply_reset(1'b1, 2);
      idle(LAT + 10);

      // Fill c0 with no pops, then keep requesting until the first pop frees
      // a slot in the same cycle as a push.
      apply_reset(1'b1, 2);
      for (int i = 0; i <= LAT; i++) begin
         drive_rd(42'(i * 4), 16'(i), 2'd0);
         step();
      end
      idle(DEPTH + LAT + 20);

      // Randomised traffic spanning a timestamp wrap.
      apply_reset(1'b1, 2);
      for (int i = 0; i < 70000; i++) begin
         if ($urandom_range(0, 15) < 2) begin
            a = 42'({$urandom(), $urandom()});
            if ($urandom_range(0, 7) == 0) a = 42'h3FFFFFFFFFE;
            case ($urandom_range(0, 31))
               0:         l = 2'd2;
               1, 2, 3,
               4, 5, 6,
               7, 8, 9:   l = 2'd3;
               10, 11, 12,
               13, 14,
               15, 16:    l = 2'd1;
               default:   l = 2'd0;
            endcase
            drive_rd(a, 16'($urandom()), l);
         end
         if ($urandom_range(0, 15) < 2)
            drive_wr(16'($urandom()), $urandom_range(0, 3) == 0);
         step();
      end
      idle(LAT + 300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
